coin_detect: RTL and testbench
==============================

COIN_DETECT -- requirements
Module: coin_detect

Interface
REQ-001 Parameter MIN_W, default 4: shortest accepted sense pulse in clock cycles; shorter pulses are glitches.
REQ-002 Parameter T25_MAX, default 20: longest pulse classified as 25 paise.
REQ-003 Parameter T50_MAX, default 40: longest pulse classified as 50 paise.
REQ-004 Parameter T100_MAX, default 80: longest pulse classified as 1 Rupee.
REQ-005 Parameter JAM_LIMIT, default 200: pulse length at which the coin path is declared jammed; legal range is T100_MAX < JAM_LIMIT <= 255.
REQ-006 clock  input  1  Single system clock; all state updates on the rising edge.
REQ-007 reset  input  1  Asynchronous, active-low reset.
REQ-008 coin_sense  input  1  Raw optical-gate level, high while a coin passes; asynchronous to clock.
REQ-009 accept_en  input  1  High when the downstream coin collector can take coins; driven from the inverse of the collector's done output.
REQ-010 coin_out  output  2  Coin code to the collector: 00 = 25p, 01 = 50p, 10 = 1R, 11 = no coin.
REQ-011 reject_out  output  1  One-cycle pulse per rejected coin.
REQ-012 jam_out  output  1  Level output, high while a jam condition persists.

Function
REQ-013 coin_sense SHALL pass through a 2-flop synchronizer; the second stage is sense_s, and all logic uses only sense_s.
REQ-014 The block SHALL implement an FSM with the states IDLE, MEASURE, EMIT, REJECT and JAM, plus an 8-bit length counter cnt.
REQ-015 IDLE: if sense_s = 1, load cnt = 1 and go to MEASURE; otherwise stay in IDLE.
REQ-016 MEASURE with sense_s = 1:
- cnt increments by 1.
- When the incremented value equals JAM_LIMIT, the FSM goes to JAM.
REQ-017 MEASURE with sense_s = 0, the pulse length L = cnt SHALL be classified as follows:
- L < MIN_W: go to IDLE, no output (glitch).
- MIN_W <= L <= T25_MAX: code 00.
- T25_MAX < L <= T50_MAX: code 01.
- T50_MAX < L <= T100_MAX: code 10.
- L > T100_MAX: go to REJECT.
REQ-018 A valid code (00/01/10) SHALL go to EMIT when accept_en = 1 in the classifying cycle, and to REJECT when accept_en = 0.
REQ-019 EMIT: coin_out = the registered code for exactly one cycle, then go to IDLE.
REQ-020 REJECT: reject_out = 1 for exactly one cycle and coin_out = 11, then go to IDLE.
REQ-021 JAM: jam_out = 1, and the FSM stays in JAM while sense_s = 1.
REQ-022 On the first cycle of JAM with sense_s = 0, the FSM SHALL go to REJECT (one reject_out pulse), and jam_out SHALL drop in that same REJECT cycle.
REQ-023 coin_out SHALL be 11 in every state except EMIT; all outputs SHALL be registered.
REQ-024 Latency: coin_out/reject_out SHALL assert exactly 1 cycle after the MEASURE cycle that sees sense_s = 0, i.e. 3 cycles after the raw falling edge.
REQ-025 At most one coin SHALL be reported per sense pulse.
REQ-026 A new rising sense_s seen in EMIT or REJECT SHALL be captured: IDLE sees sense_s and starts a fresh count on the following cycle.
REQ-027 cnt SHALL never wrap, because JAM_LIMIT <= 255 stops counting before overflow.
REQ-028 accept_en SHALL be sampled only in the classifying cycle; changes during MEASURE have no effect.

Reset
REQ-029 When reset is low, the block SHALL asynchronously force the following, regardless of clock:
- FSM to IDLE, cnt = 0, synchronizer flops = 0.
- coin_out = 11, reject_out = 0, jam_out = 0.
REQ-030 A coin in flight during reset SHALL be discarded; after release, a sense level still high SHALL be measured as a new, shorter pulse from the point of release.
REQ-031 Reset release SHALL be synchronous-deasserted externally; the block SHALL produce no output pulse on the release edge.

Verification
REQ-032 accept_en = 1, raw pulse of 10 cycles -> coin_out = 00 for exactly one cycle, 3 cycles after the falling edge; no reject_out.
REQ-033 accept_en = 1, pulses of 30, 60, 90 cycles -> coin_out = 01, then 10, then reject_out pulse with coin_out = 11.
REQ-034 Pulse of 3 cycles -> no coin_out change and no reject_out; pulse of exactly 4, 20, 21, 40, 41, 80 cycles -> 00, 00, 01, 01, 10, 10 (boundary check).
REQ-035 accept_en = 0, pulse of 30 cycles -> reject_out pulse and coin_out stays 11; accept_en toggling mid-pulse but 1 at the fall -> coin_out = 01.
REQ-036 sense held high 300 cycles -> jam_out rises at synchronized count 200 and stays high until the fall; then one reject_out pulse with jam_out = 0 in that cycle.
REQ-037 reset asserted low mid-pulse at count 15 -> outputs immediately reset; sense held 10 more cycles after release -> coin_out = 00.

Source files
------------

// File: rtl/coin_detect.sv
// Coin classifier: measures synchronized optical-gate pulse width, reports a coin
// code, a reject pulse, or a jam level to the downstream collector.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for sense_s to rise
// MEASURE | counting pulse length in cnt while sense_s is high
// EMIT    | coin_out carries the classified code for one cycle
// REJECT  | one-cycle reject_out pulse (bad length, no acceptor, jam end)
// JAM     | pulse reached JAM_LIMIT; jam_out held until sense_s falls
module coin_detect #(
    parameter int MIN_W     = 4,
    parameter int T25_MAX   = 20,
    parameter int T50_MAX   = 40,
    parameter int T100_MAX  = 80,
    parameter int JAM_LIMIT = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_sense,
    input  logic       accept_en,
    output logic [1:0] coin_out,
    output logic       reject_out,
    output logic       jam_out
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MEASURE = 3'd1;
    localparam logic [2:0] EMIT    = 3'd2;
    localparam logic [2:0] REJECT  = 3'd3;
    localparam logic [2:0] JAM     = 3'd4;

    localparam logic [7:0] MIN_W_C     = 8'(MIN_W);
    localparam logic [7:0] T25_MAX_C   = 8'(T25_MAX);
    localparam logic [7:0] T50_MAX_C   = 8'(T50_MAX);
    localparam logic [7:0] T100_MAX_C  = 8'(T100_MAX);
    localparam logic [7:0] JAM_LIMIT_C = 8'(JAM_LIMIT);

    localparam logic [1:0] CODE_25P  = 2'b00;
    localparam logic [1:0] CODE_50P  = 2'b01;
    localparam logic [1:0] CODE_1R   = 2'b10;
    localparam logic [1:0] CODE_NONE = 2'b11;

    logic       sense_m;
    logic       sense_s;
    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] cnt_inc;
    logic [1:0] code_cls;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sense_m <= 1'b0;
            sense_s <= 1'b0;
        end else begin
            sense_m <= coin_sense;
            sense_s <= sense_m;
        end
    end

    assign cnt_inc = cnt + 8'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_cls  = CODE_NONE;
        case (state)
            IDLE: begin
                if (sense_s) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (sense_s) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == JAM_LIMIT_C) begin
                        state_nxt = JAM;
                    end
                end else if (cnt < MIN_W_C) begin
                    state_nxt = IDLE;
                end else if (cnt > T100_MAX_C) begin
                    state_nxt = REJECT;
                end else begin
                    if (cnt <= T25_MAX_C) begin
                        code_cls = CODE_25P;
                    end else if (cnt <= T50_MAX_C) begin
                        code_cls = CODE_50P;
                    end else begin
                        code_cls = CODE_1R;
                    end
                    // accept_en matters only in this classifying cycle
                    state_nxt = accept_en ? EMIT : REJECT;
                end
            end
            EMIT:    state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            JAM: begin
                if (!sense_s) begin
                    state_nxt = REJECT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            coin_out   <= CODE_NONE;
            reject_out <= 1'b0;
            jam_out    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            coin_out   <= (state_nxt == EMIT) ? code_cls : CODE_NONE;
            reject_out <= (state_nxt == REJECT);
            jam_out    <= (state_nxt == JAM);
        end
    end

endmodule

// File: tb/tb_coin_detect.sv
// Bench for coin_detect: pulse-level schedule planned up front, expected outputs
// derived per pulse from its length, checked every cycle plus literal pins.
module tb_coin_detect;

    localparam int MIN_W     = 4;
    localparam int T25_MAX   = 20;
    localparam int T50_MAX   = 40;
    localparam int T100_MAX  = 80;
    localparam int JAM_LIMIT = 200;
    localparam int NC        = 24000;

    logic       clock = 1'b0;
    logic       reset;
    logic       coin_sense;
    logic       accept_en;
    logic [1:0] coin_out;
    logic       reject_out;
    logic       jam_out;

    always #5 clock = ~clock;

    coin_detect #(
        .MIN_W(MIN_W), .T25_MAX(T25_MAX), .T50_MAX(T50_MAX),
        .T100_MAX(T100_MAX), .JAM_LIMIT(JAM_LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .coin_sense(coin_sense),
        .accept_en(accept_en), .coin_out(coin_out),
        .reject_out(reject_out), .jam_out(jam_out)
    );

    // index = clock edge number; plan_* are the values seen at that edge,
    // exp_* are the outputs required just after that edge
    bit         plan_raw [NC];
    bit         plan_acc [NC];
    bit         plan_rstn[NC];
    logic [1:0] exp_coin [NC];
    bit         exp_rej  [NC];
    bit         exp_jam  [NC];

    typedef struct {
        int         cyc;
        logic [1:0] coin;
        bit         rej;
        bit         jam;
    } pin_t;
    pin_t pins[$];

    int ready_edge;
    int n_tests;
    int n_fail;
    int last_edge;

    function automatic void pin(int c, logic [1:0] co, bit rj, bit jm);
        pin_t p;
        p.cyc = c; p.coin = co; p.rej = rj; p.jam = jm;
        pins.push_back(p);
    endfunction

    // Raw gate high for samples a..a+p-1. The sensed pulse reaches the
    // classifier two edges later; if the block is still busy with the previous
    // coin the start of the pulse is lost and the measured length shrinks.
    function automatic void add_pulse(int a, int p);
        int s, l, c;
        for (int i = a; i < a + p; i++) plan_raw[i] = 1'b1;
        s = (a + 2 > ready_edge) ? a + 2 : ready_edge;
        l = p - (s - a - 2);
        c = a + p + 2;
        if (l <= 0) return;
        if (l >= JAM_LIMIT) begin
            for (int j = s + JAM_LIMIT - 1; j < c; j++) exp_jam[j] = 1'b1;
            exp_rej[c] = 1'b1;
            ready_edge = c + 2;
        end else if (l < MIN_W) begin
            ready_edge = c + 1;
        end else if (l > T100_MAX) begin
            exp_rej[c] = 1'b1;
            ready_edge = c + 2;
        end else begin
            if (plan_acc[c]) begin
                if (l <= T25_MAX)      exp_coin[c] = 2'b00;
                else if (l <= T50_MAX) exp_coin[c] = 2'b01;
                else                   exp_coin[c] = 2'b10;
            end else begin
                exp_rej[c] = 1'b1;
            end
            ready_edge = c + 2;
        end
    endfunction

    function automatic void add_reset(int lo, int rel);
        for (int i = lo; i < rel; i++) plan_rstn[i] = 1'b0;
        ready_edge = 0;
    endfunction

    task automatic check_edge(int e);
        n_tests++;
        if (coin_out !== exp_coin[e] || reject_out !== exp_rej[e] || jam_out !== exp_jam[e]) begin
            n_fail++;
            $display("FAIL model_cmp edge %0d: coin/rej/jam got %b/%b/%b want %b/%b/%b",
                     e, coin_out, reject_out, jam_out, exp_coin[e], exp_rej[e], exp_jam[e]);
        end
        foreach (pins[i]) begin
            if (pins[i].cyc == e) begin
                n_tests++;
                if (coin_out !== pins[i].coin || reject_out !== pins[i].rej || jam_out !== pins[i].jam) begin
                    n_fail++;
                    $display("FAIL pin edge %0d: coin/rej/jam got %b/%b/%b want %b/%b/%b",
                             e, coin_out, reject_out, jam_out, pins[i].coin, pins[i].rej, pins[i].jam);
                end
            end
        end
    endtask

    task automatic drive_edge(int e);
        if (!plan_rstn[e] && reset === 1'b1) begin
            reset = 1'b0;
            #1;
            n_tests++;
            if (coin_out !== 2'b11 || reject_out !== 1'b0 || jam_out !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset edge %0d: coin/rej/jam got %b/%b/%b want 11/0/0",
                         e, coin_out, reject_out, jam_out);
            end
        end else begin
            reset = plan_rstn[e];
        end
        coin_sense = plan_raw[e];
        accept_en  = plan_acc[e];
    endtask

    initial begin
        int t, a, p, g, r;
        n_tests = 0;
        n_fail  = 0;
        ready_edge = 0;
        for (int i = 0; i < NC; i++) begin
            plan_raw[i] = 1'b0; plan_acc[i] = 1'b1; plan_rstn[i] = 1'b1;
            exp_coin[i] = 2'b11; exp_rej[i] = 1'b0; exp_jam[i] = 1'b0;
        end
        add_reset(0, 5);

        // first coin: 10-cycle pulse, code 00 at edge 22 only
        add_pulse(10, 10);
        pin(21, 2'b11, 1'b0, 1'b0);
        pin(22, 2'b00, 1'b0, 1'b0);
        pin(23, 2'b11, 1'b0, 1'b0);
        t = 28;

        add_pulse(t, 30); pin(t + 32, 2'b01, 1'b0, 1'b0); t += 38;
        add_pulse(t, 60); pin(t + 62, 2'b10, 1'b0, 1'b0); t += 68;
        add_pulse(t, 90); pin(t + 92, 2'b11, 1'b1, 1'b0); t += 98;
        add_pulse(t, 3);  pin(t + 5,  2'b11, 1'b0, 1'b0); t += 11;
        add_pulse(t, 4);  pin(t + 6,  2'b00, 1'b0, 1'b0); t += 12;
        add_pulse(t, 20); pin(t + 22, 2'b00, 1'b0, 1'b0); t += 28;
        add_pulse(t, 21); pin(t + 23, 2'b01, 1'b0, 1'b0); t += 29;
        add_pulse(t, 40); pin(t + 42, 2'b01, 1'b0, 1'b0); t += 48;
        add_pulse(t, 41); pin(t + 43, 2'b10, 1'b0, 1'b0); t += 49;
        add_pulse(t, 80); pin(t + 82, 2'b10, 1'b0, 1'b0); t += 88;

        // collector busy: 30-cycle coin rejected
        plan_acc[t + 32] = 1'b0;
        add_pulse(t, 30); pin(t + 32, 2'b11, 1'b1, 1'b0); t += 38;

        // accept_en toggling during the pulse, high when classified
        for (int i = t; i < t + 32; i++) plan_acc[i] = 1'($urandom_range(0, 1));
        plan_acc[t + 32] = 1'b1;
        add_pulse(t, 30); pin(t + 32, 2'b01, 1'b0, 1'b0); t += 38;

        // 300-cycle jam
        add_pulse(t, 300);
        pin(t + 200, 2'b11, 1'b0, 1'b0);
        pin(t + 201, 2'b11, 1'b0, 1'b1);
        pin(t + 301, 2'b11, 1'b0, 1'b1);
        pin(t + 302, 2'b11, 1'b1, 1'b0);
        pin(t + 303, 2'b11, 1'b0, 1'b0);
        t += 310;

        // reset at count 15, gate stays high 10 samples after release
        a = t;
        for (int i = a; i < a + 20; i++) plan_raw[i] = 1'b1;
        add_reset(a + 17, a + 20);
        add_pulse(a + 20, 10);
        pin(a + 32, 2'b00, 1'b0, 1'b0);
        t = a + 40;

        // reset while jammed: jam_out must fall at once, then a fresh 30 pulse
        a = t;
        for (int i = a; i < a + 218; i++) plan_raw[i] = 1'b1;
        for (int j = a + 201; j < a + 215; j++) exp_jam[j] = 1'b1;
        pin(a + 214, 2'b11, 1'b0, 1'b1);
        add_reset(a + 215, a + 218);
        add_pulse(a + 218, 30);
        pin(a + 250, 2'b01, 1'b0, 1'b0);
        t = a + 258;

        // randomized traffic, including back-to-back pulses and jams
        for (int i = t; i < NC; i++) plan_acc[i] = 1'($urandom_range(0, 3) != 0);
        for (int k = 0; k < 160; k++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)     p = int'($urandom_range(195, 230));
            else if (r < 4) p = int'($urandom_range(1, 6));
            else            p = int'($urandom_range(7, 95));
            g = int'($urandom_range(1, 8));
            if (t + p + g + 10 >= NC) break;
            add_pulse(t, p);
            t += p + g;
        end
        last_edge = t + 20;

        drive_edge(1);
        for (int e = 1; e < last_edge; e++) begin
            @(posedge clock);
            #1;
            check_edge(e);
            @(negedge clock);
            drive_edge(e + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
